// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit I2C target with oversampled SCL/SDA, write strobe and one-entry read buffer
module i2c_slave #(
    parameter logic [6:0] p_ADDR = 7'h42
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    inout  wire        io_sda,
    inout  wire        io_scl,
    input  logic [7:0] inp_data,
    input  logic       inp_en,
    output logic       inp_rdy,
    output logic [7:0] out_data,
    output logic       out_rdy,
    output logic       o_busy
);
    localparam logic [2:0] s_IDLE     = 3'd0;
    localparam logic [2:0] s_ADDR     = 3'd1;
    localparam logic [2:0] s_ADDR_ACK = 3'd2;
    localparam logic [2:0] s_WRITE    = 3'd3;
    localparam logic [2:0] s_WR_ACK   = 3'd4;
    localparam logic [2:0] s_READ     = 3'd5;
    localparam logic [2:0] s_RD_ACK   = 3'd6;
    logic [2:0] scl_s, sda_s, state;
    logic [3:0] bit_cnt;
    logic [6:0] rx, tx;
    logic [7:0] buf_data, rx_next, tx_src;
    logic       buf_full, rw, ack_ph, sda_low;
    logic       scl_hi, scl_rise, scl_fall, start, stop, take;

    assign io_sda  = sda_low ? 1'b0 : 1'bz;
    assign inp_rdy = ~buf_full;

    // bus events from the synchronized pins, plus the TX-buffer consume strobe
    always_comb begin
        scl_hi   = scl_s[1] | scl_s[2];
        scl_rise = scl_s[1] & ~scl_s[2];
        scl_fall = ~scl_s[1] & scl_s[2];
        start    = scl_hi & ~sda_s[1] & sda_s[2];
        stop     = scl_hi & sda_s[1] & ~sda_s[2];
        rx_next  = {rx, sda_s[1]};
        tx_src   = buf_full ? buf_data : 8'hFF;
        take     = scl_fall & ~start & ~stop & ack_ph &
                   ((state == s_ADDR_ACK & rw) | (state == s_RD_ACK));
    end

    // two synchronizer stages plus a history stage for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_s <= '1;
            sda_s <= '1;
        end else begin
            scl_s <= {scl_s[1:0], io_scl};
            sda_s <= {sda_s[1:0], io_sda};
        end
    end

    // one-entry TX buffer; a consume in the same cycle blocks a new load
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (take) begin
            buf_full <= 1'b0;
        end else if (inp_en && !buf_full) begin
            buf_full <= 1'b1;
            buf_data <= inp_data;
        end
    end

    // protocol FSM: START/STOP first, then per-state bit handling on SCL edges
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= s_IDLE;
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            rw       <= 1'b0;
            ack_ph   <= 1'b0;
            sda_low  <= 1'b0;
            o_busy   <= 1'b0;
            out_data <= '0;
            out_rdy  <= 1'b0;
        end else begin
            out_rdy <= 1'b0;
            if (start) begin
                state   <= s_ADDR;
                bit_cnt <= '0;
                sda_low <= 1'b0;
                o_busy  <= 1'b0;
            end else if (stop) begin
                state   <= s_IDLE;
                sda_low <= 1'b0;
                o_busy  <= 1'b0;
            end else begin
                case (state)
                    s_ADDR: if (scl_rise) begin
                        rx      <= rx_next[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (rx == p_ADDR) begin
                                state  <= s_ADDR_ACK;
                                rw     <= sda_s[1];
                                ack_ph <= 1'b0;
                                o_busy <= 1'b1;
                            end else begin
                                state <= s_IDLE;
                            end
                        end
                    end
                    s_ADDR_ACK, s_WR_ACK: if (scl_fall) begin
                        if (!ack_ph) begin
                            sda_low <= 1'b1;
                            ack_ph  <= 1'b1;
                        end else if (state == s_ADDR_ACK && rw) begin
                            tx      <= tx_src[6:0];
                            sda_low <= ~tx_src[7];
                            bit_cnt <= '0;
                            state   <= s_READ;
                        end else begin
                            sda_low <= 1'b0;
                            bit_cnt <= '0;
                            state   <= s_WRITE;
                        end
                    end
                    s_WRITE: if (scl_rise) begin
                        rx      <= rx_next[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            out_data <= rx_next;
                            out_rdy  <= 1'b1;
                            ack_ph   <= 1'b0;
                            state    <= s_WR_ACK;
                        end
                    end
                    s_READ: if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            sda_low <= 1'b0;
                            ack_ph  <= 1'b0;
                            state   <= s_RD_ACK;
                        end else begin
                            tx      <= {tx[5:0], 1'b0};
                            sda_low <= ~tx[6];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    s_RD_ACK: begin
                        if (scl_rise && !ack_ph) begin
                            if (sda_s[1]) begin
                                state  <= s_IDLE;
                                o_busy <= 1'b0;
                            end else begin
                                ack_ph <= 1'b1;
                            end
                        end else if (scl_fall && ack_ph) begin
                            tx      <= tx_src[6:0];
                            sda_low <= ~tx_src[7];
                            bit_cnt <= '0;
                            state   <= s_READ;
                        end
                    end
                    default: state <= s_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with scoreboard queues for written and read bytes
module tb_i2c_slave;
    localparam int Q = 100;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] inp_data = '0;
    logic       inp_en = 1'b0;
    logic       inp_rdy, out_rdy, o_busy;
    logic [7:0] out_data;
    logic       m_scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda, scl;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_left;
    logic [7:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] rd_byte, d;
    logic       prev_rdy = 1'b0;
    logic       a;
    event       rd_ev;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;
    assign scl = m_scl;

    i2c_slave #(.p_ADDR(7'h42)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .io_sda(sda), .io_scl(scl),
        .inp_data(inp_data), .inp_en(inp_en), .inp_rdy(inp_rdy),
        .out_data(out_data), .out_rdy(out_rdy), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, got, exp);
        end
    endtask

    task automatic bus_start;
        m_sda_low = 1'b0;
        #Q m_scl = 1'b1;
        #Q m_sda_low = 1'b1;
        #Q m_scl = 1'b0;
        #Q;
    endtask

    task automatic bus_stop;
        m_sda_low = 1'b1;
        #Q m_scl = 1'b1;
        #Q m_sda_low = 1'b0;
        #Q;
    endtask

    task automatic put_bit(input logic b);
        m_sda_low = ~b;
        #Q m_scl = 1'b1;
        #(2*Q) m_scl = 1'b0;
        #Q;
    endtask

    task automatic get_bit(output logic b);
        m_sda_low = 1'b0;
        #Q m_scl = 1'b1;
        #Q b = sda;
        #Q m_scl = 1'b0;
        #Q;
    endtask

    task automatic wr_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic rd_byte_t(input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            rd_byte[i] = b;
        end
        -> rd_ev;
        put_bit(nack);
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge i_clk);
        inp_data = v;
        inp_en = 1'b1;
        @(negedge i_clk);
        inp_en = 1'b0;
        chk1("inp_rdy_after_load", inp_rdy, 1'b0);
    endtask

    // write-side monitor: every out_rdy pulse must match the next expected byte
    initial forever begin
        @(negedge i_clk);
        if (out_rdy) begin
            if (exp_wr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_rdy_unexpected: got strobe with out_data %02h, expected none", out_data);
            end else begin
                chk("out_data", out_data, exp_wr.pop_front());
            end
            chk1("out_rdy_width", prev_rdy, 1'b0);
        end
        prev_rdy = out_rdy;
    end

    // read-side monitor: each byte seen on the bus must match the next expected byte
    initial forever begin
        @(rd_ev);
        if (exp_rd.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_unexpected: got %02h, expected no byte", rd_byte);
        end else begin
            chk("rd_byte", rd_byte, exp_rd.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #15;
        chk1("rst_inp_rdy", inp_rdy, 1'b1);
        chk("rst_out_data", out_data, 8'h00);
        chk1("rst_out_rdy", out_rdy, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_sda", sda, 1'b1);
        i_rst_n = 1'b1;
        #(4*Q);
        // reset asserted while the target holds the address ACK low
        bus_start;
        d = 8'h84;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        m_sda_low = 1'b0;
        #1;
        chk1("midack_sda_low", sda, 1'b0);
        chk1("midack_busy", o_busy, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk1("midack_rst_sda", sda, 1'b1);
        chk1("midack_rst_inp_rdy", inp_rdy, 1'b1);
        chk1("midack_rst_out_rdy", out_rdy, 1'b0);
        chk1("midack_rst_busy", o_busy, 1'b0);
        #20 i_rst_n = 1'b1;
        bus_stop;
        #(2*Q);
        // write to matched address
        bus_start;
        wr_byte(8'h84, a);
        chk1("wr_addr_ack", a, 1'b0);
        exp_wr.push_back(8'hA5);
        wr_byte(8'hA5, a);
        chk1("wr_d0_ack", a, 1'b0);
        exp_wr.push_back(8'h3C);
        wr_byte(8'h3C, a);
        chk1("wr_d1_ack", a, 1'b0);
        chk1("wr_busy", o_busy, 1'b1);
        bus_stop;
        #Q;
        chk1("wr_busy_after_stop", o_busy, 1'b0);
        // address mismatch
        bus_start;
        wr_byte(8'h86, a);
        chk1("mm_addr_nack", a, 1'b1);
        chk1("mm_busy", o_busy, 1'b0);
        wr_byte(8'h11, a);
        chk1("mm_data_nack", a, 1'b1);
        bus_stop;
        #Q;
        // read with buffer; the second load while full must be ignored
        chk1("rd_rdy_empty", inp_rdy, 1'b1);
        load(8'h96);
        load(8'h77);
        bus_start;
        wr_byte(8'h85, a);
        chk1("rd_addr_ack", a, 1'b0);
        chk1("rd_rdy_after_take", inp_rdy, 1'b1);
        load(8'h0F);
        exp_rd.push_back(8'h96);
        rd_byte_t(1'b0);
        exp_rd.push_back(8'h0F);
        rd_byte_t(1'b1);
        chk1("rd_busy_after_nack", o_busy, 1'b0);
        chk1("rd_sda_released", sda, 1'b1);
        bus_stop;
        #Q;
        // read underflow
        bus_start;
        wr_byte(8'h85, a);
        chk1("uf_addr_ack", a, 1'b0);
        exp_rd.push_back(8'hFF);
        rd_byte_t(1'b1);
        bus_stop;
        #Q;
        // write then repeated START into a read
        load(8'h5A);
        bus_start;
        wr_byte(8'h84, a);
        chk1("rs_waddr_ack", a, 1'b0);
        exp_wr.push_back(8'h01);
        wr_byte(8'h01, a);
        chk1("rs_wdata_ack", a, 1'b0);
        bus_start;
        wr_byte(8'h85, a);
        chk1("rs_raddr_ack", a, 1'b0);
        chk1("rs_busy", o_busy, 1'b1);
        exp_rd.push_back(8'h5A);
        rd_byte_t(1'b1);
        bus_stop;
        #(4*Q);
        n_left = exp_wr.size();
        chk("wr_queue_left", n_left[7:0], 8'h00);
        n_left = exp_rd.size();
        chk("rd_queue_left", n_left[7:0], 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
